// File: rtl/ace_ccu_conflict_manager.sv
// Address-conflict scheduler for the CCU snoop path: tracks in-flight snoop line
// addresses in issue order and stalls new snoops that conflict or find the table full.
module ace_ccu_conflict_manager #(
    parameter int unsigned CmAddrWidth = 16,
    parameter int unsigned MaxTrans    = 4,
    localparam int unsigned CntWidth   = $clog2(MaxTrans + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cm_valid_i,
    input  logic                   cm_ready_i,
    input  logic [CmAddrWidth-1:0] cm_addr_i,
    output logic                   cm_stall_o,
    input  logic                   cm_done_i,
    output logic [CntWidth-1:0]    occupancy_o,
    output logic                   full_o,
    output logic                   err_o
);

    localparam int unsigned PtrW = $clog2(MaxTrans);

    logic                   valid_q [MaxTrans];
    logic                   valid_d [MaxTrans];
    logic [CmAddrWidth-1:0] addr_q  [MaxTrans];
    logic [CmAddrWidth-1:0] addr_d  [MaxTrans];
    logic [PtrW-1:0]        wr_q, wr_d;
    logic [PtrW-1:0]        rd_q, rd_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic hit;
    logic full;
    logic acc;
    logic ret;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MaxTrans; i++) begin
            if (valid_q[i] && (addr_q[i] == cm_addr_i)) begin
                hit = 1'b1;
            end
        end
    end

    // Stall never looks at cm_ready_i, so no combinational loop through the interconnect.
    assign full       = (cnt_q == CntWidth'(MaxTrans));
    assign cm_stall_o = cm_valid_i && (hit || full);
    assign acc        = cm_valid_i && cm_ready_i && !cm_stall_o;
    assign ret        = cm_done_i && (cnt_q != '0);

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (acc) begin
            valid_d[wr_q] = 1'b1;
            addr_d[wr_q]  = cm_addr_i;
            wr_d          = wr_q + PtrW'(1);
        end
        // acc and ret never target the same slot: acc needs a free slot, ret an occupied one.
        if (ret) begin
            valid_d[rd_q] = 1'b0;
            rd_d          = rd_q + PtrW'(1);
        end

        unique case ({acc, ret})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase

        if (cm_done_i && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxTrans; i++) begin
                valid_q[i] <= 1'b0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Address payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
    end

    assign occupancy_o = cnt_q;
    assign full_o      = full;
    assign err_o       = err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (cnt_q <= CntWidth'(MaxTrans));
            assert (!$isunknown(cm_done_i));
        end
    end
`endif

endmodule

// File: tb/tb_ace_ccu_conflict_manager.sv
// Self-checking bench for ace_ccu_conflict_manager: table-driven cycles with a
// scoreboard queue for registered outputs, plus hand sequences for wrap, error and reset.
module tb_ace_ccu_conflict_manager;

    localparam int unsigned AW   = 16;
    localparam int unsigned MT   = 4;
    localparam int unsigned CW   = $clog2(MT + 1);

    logic          clk_i;
    logic          rst_ni;
    logic          cm_valid_i;
    logic          cm_ready_i;
    logic [AW-1:0] cm_addr_i;
    logic          cm_stall_o;
    logic          cm_done_i;
    logic [CW-1:0] occupancy_o;
    logic          full_o;
    logic          err_o;

    ace_ccu_conflict_manager #(
        .CmAddrWidth (AW),
        .MaxTrans    (MT)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cm_valid_i  (cm_valid_i),
        .cm_ready_i  (cm_ready_i),
        .cm_addr_i   (cm_addr_i),
        .cm_stall_o  (cm_stall_o),
        .cm_done_i   (cm_done_i),
        .occupancy_o (occupancy_o),
        .full_o      (full_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          v;
        logic          r;
        logic [AW-1:0] addr;
        logic          d;
        logic          e_stall;
        int            e_occ;
        logic          e_full;
        logic          e_err;
    } vec_t;

    typedef struct {
        int   occ;
        logic full;
        logic err;
        int   idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic v, logic r, logic [AW-1:0] a, logic d,
                                logic es, int eo, logic ef, logic ee);
        vec_t t;
        t.v = v; t.r = r; t.addr = a; t.d = d;
        t.e_stall = es; t.e_occ = eo; t.e_full = ef; t.e_err = ee;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check stall before the edge, registered state after.
    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        @(negedge clk_i);
        cm_valid_i = t.v;
        cm_ready_i = t.r;
        cm_addr_i  = t.addr;
        cm_done_i  = t.d;
        e.occ  = t.e_occ;
        e.full = t.e_full;
        e.err  = t.e_err;
        e.idx  = idx;
        sb.push_back(e);
        #1;
        check($sformatf("vec%0d stall", idx), int'(cm_stall_o), int'(t.e_stall));
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL vec%0d scoreboard empty", idx);
        end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d occupancy", e.idx), int'(occupancy_o), e.occ);
            check($sformatf("vec%0d full", e.idx), int'(full_o), int'(e.full));
            check($sformatf("vec%0d err", e.idx), int'(err_o), int'(e.err));
        end
    endtask

    initial begin
        rst_ni     = 1'b0;
        cm_valid_i = 1'b1;
        cm_ready_i = 1'b0;
        cm_addr_i  = 16'h0040;
        cm_done_i  = 1'b0;
        #12;
        check("reset stall", int'(cm_stall_o), 0);
        check("reset occupancy", int'(occupancy_o), 0);
        check("reset full", int'(full_o), 0);
        check("reset err", int'(err_o), 0);
        cm_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        //             v  r  addr      d  stall occ full err
        tbl.push_back(mk(1, 1, 16'h0040, 0, 0, 1, 0, 0)); // accept first snoop
        tbl.push_back(mk(1, 0, 16'h0040, 0, 1, 1, 0, 0)); // same line now hits
        tbl.push_back(mk(1, 1, 16'h0040, 1, 1, 0, 0, 0)); // retire: still stalled this cycle
        tbl.push_back(mk(1, 1, 16'h0040, 0, 0, 1, 0, 0)); // accepted next cycle
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0010, 0, 0, 1, 0, 0)); // fill table
        tbl.push_back(mk(1, 1, 16'h0020, 0, 0, 2, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0030, 0, 0, 3, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0040, 0, 0, 4, 1, 0));
        tbl.push_back(mk(1, 1, 16'h0050, 0, 1, 4, 1, 0)); // full stalls
        tbl.push_back(mk(1, 1, 16'h0050, 1, 1, 3, 0, 0)); // retire does not unblock same cycle
        tbl.push_back(mk(1, 1, 16'h0050, 0, 0, 4, 1, 0)); // accepted next cycle
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 2, 0, 0)); // in flight: 0040, 0050
        tbl.push_back(mk(1, 1, 16'h0099, 1, 0, 2, 0, 0)); // accept + retire together
        tbl.push_back(mk(1, 0, 16'h0040, 0, 0, 2, 0, 0)); // retired oldest no longer hits
        tbl.push_back(mk(0, 1, 16'h0050, 0, 0, 2, 0, 0)); // no valid, no stall
        tbl.push_back(mk(1, 0, 16'h0050, 0, 1, 2, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0099, 0, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Pointer wrap: ten issue/retire pairs; previous address must not linger.
        for (int k = 0; k < 10; k++) begin
            logic [AW-1:0] a;
            a = 16'h0100 + AW'(k);
            if (k > 0) apply(mk(1, 0, a - 16'h0001, 0, 0, 0, 0, 0), 100 + 3 * k);
            apply(mk(1, 1, a, 0, 0, 1, 0, 0), 101 + 3 * k);
            apply(mk(0, 0, 16'h0000, 1, 0, 0, 0, 0), 102 + 3 * k);
        end

        // Done on empty table sets sticky error.
        apply(mk(0, 0, 16'h0000, 1, 0, 0, 0, 1), 200);
        apply(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1), 201);
        apply(mk(1, 1, 16'h0A00, 0, 0, 1, 0, 1), 202);
        apply(mk(1, 1, 16'h0B00, 0, 0, 2, 0, 1), 203);
        apply(mk(1, 1, 16'h0C00, 0, 0, 3, 0, 1), 204);

        // Asynchronous reset mid-cycle with three entries in flight.
        @(negedge clk_i);
        cm_valid_i = 1'b1;
        cm_ready_i = 1'b0;
        cm_addr_i  = 16'h0A00;
        cm_done_i  = 1'b0;
        #1;
        check("pre-reset stall on hit", int'(cm_stall_o), 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("async reset occupancy", int'(occupancy_o), 0);
        check("async reset err", int'(err_o), 0);
        check("async reset stall", int'(cm_stall_o), 0);
        check("async reset full", int'(full_o), 0);
        @(negedge clk_i);
        cm_valid_i = 1'b0;
        rst_ni     = 1'b1;
        apply(mk(1, 1, 16'h0A00, 0, 0, 1, 0, 0), 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
